// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decides when the front of the five-stage pipeline holds,
// flushes or bubbles. It covers load-use hazards, taken-branch redirects and
// the fixed-latency multiply that occupies EX. It also keeps a saturating
// count of decode-stall cycles for performance monitoring.
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             UsesRtD,
    input  logic [4:0]       RtE,
    input  logic             MemReadE,
    input  logic             BranchTakenE,
    input  logic             MulStartE,
    output logic             StallF,
    output logic             IF_IDWrite,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulDoneE,
    output logic [CNT_W-1:0] StallCount
);

    // The down-counter only has to hold MUL_LAT-2, so ceil(log2(MUL_LAT)) bits are enough.
    localparam int CW = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_START = CW'(MUL_LAT - 2);

    typedef enum logic {
        RUN,
        MUL_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stallCount_q, stallCount_d;

    logic loadUse;
    logic stallFRaw, ifIdWriteRaw, flushDRaw, stallERaw, flushERaw, flushMRaw, mulDoneRaw;

    // A load in EX writes a register that the ID instruction is about to read. r0 never counts.
    assign loadUse = MemReadE && (RtE != 5'd0) &&
                     ((RtE == RsD) || (UsesRtD && (RtE == RtD)));

    // Next-state and Mealy control outputs. In RUN, priority is branch, then multiply, then load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stallFRaw    = 1'b0;
        ifIdWriteRaw = 1'b0;
        flushDRaw    = 1'b0;
        stallERaw    = 1'b0;
        flushERaw    = 1'b0;
        flushMRaw    = 1'b0;
        mulDoneRaw   = 1'b0;
        case (state_q)
            RUN: begin
                if (BranchTakenE) begin
                    flushDRaw = 1'b1;
                    flushERaw = 1'b1;
                end else if (MulStartE) begin
                    stallFRaw    = 1'b1;
                    ifIdWriteRaw = 1'b1;
                    stallERaw    = 1'b1;
                    flushMRaw    = 1'b1;
                    state_d      = MUL_BUSY;
                    cnt_d        = CNT_START;
                end else if (loadUse) begin
                    stallFRaw    = 1'b1;
                    ifIdWriteRaw = 1'b1;
                    flushERaw    = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    stallFRaw    = 1'b1;
                    ifIdWriteRaw = 1'b1;
                    stallERaw    = 1'b1;
                    flushMRaw    = 1'b1;
                    cnt_d        = cnt_q - CW'(1);
                end else begin
                    // Release cycle: the product is valid. A new multiply cannot start here.
                    mulDoneRaw = 1'b1;
                    state_d    = RUN;
                    if (BranchTakenE) begin
                        flushDRaw = 1'b1;
                        flushERaw = 1'b1;
                    end else if (loadUse) begin
                        stallFRaw    = 1'b1;
                        ifIdWriteRaw = 1'b1;
                        flushERaw    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // While reset is held, every control output is forced low, even though it is combinational.
    assign StallF     = reset_n & stallFRaw;
    assign IF_IDWrite = reset_n & ifIdWriteRaw;
    assign FlushD     = reset_n & flushDRaw;
    assign StallE     = reset_n & stallERaw;
    assign FlushE     = reset_n & flushERaw;
    assign FlushM     = reset_n & flushMRaw;
    assign MulDoneE   = reset_n & mulDoneRaw;
    assign StallCount = stallCount_q;

    // Count decode-stall cycles and stop at all-ones instead of wrapping.
    always_comb begin
        stallCount_d = stallCount_q;
        if (IF_IDWrite && (stallCount_q != '1)) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    // State, multiply countdown and stall counter. Reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stallCount_q <= stallCount_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random stimulus for hazard_stall_ctrl.
// The reference model tracks "cycles until the multiply result" and an integer
// stall total. It predicts every control output and StallCount each cycle.
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       RsD, RtD, RtE;
    logic             UsesRtD, MemReadE, BranchTakenE, MulStartE;
    logic             StallF, IF_IDWrite, FlushD, StallE, FlushE, FlushM, MulDoneE;
    logic [CNT_W-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Model state: cyclesToDone = 0 means idle; 1 means this is the result cycle.
    int cyclesToDone = 0;
    int modelCount   = 0;

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .RsD(RsD), .RtD(RtD), .UsesRtD(UsesRtD), .RtE(RtE),
        .MemReadE(MemReadE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .StallF(StallF), .IF_IDWrite(IF_IDWrite), .FlushD(FlushD), .StallE(StallE),
        .FlushE(FlushE), .FlushM(FlushM), .MulDoneE(MulDoneE), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // Expected controls packed as {StallF, IF_IDWrite, FlushD, StallE, FlushE, FlushM, MulDoneE}.
    function automatic logic [6:0] expCtrl();
        logic lu;
        logic [6:0] e;
        e  = 7'b0;
        lu = MemReadE && (RtE != 0) && ((RtE == RsD) || (UsesRtD && (RtE == RtD)));
        if (!reset_n) return 7'b0;
        if (cyclesToDone > 1) begin
            e = 7'b1101010;
        end else begin
            if (cyclesToDone == 1) e[0] = 1'b1;
            if (BranchTakenE)                        e = e | 7'b0010100;
            else if (MulStartE && cyclesToDone == 0) e = e | 7'b1101010;
            else if (lu)                             e = e | 7'b1100100;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic [4:0] rtE, input logic memRead,
                                 input logic br, input logic mul);
        RsD = rs; RtD = rt; UsesRtD = usesRt; RtE = rtE;
        MemReadE = memRead; BranchTakenE = br; MulStartE = mul;
    endtask

    task automatic checkOutput(input string tag);
        logic [6:0] act;
        logic [6:0] exp;
        act = {StallF, IF_IDWrite, FlushD, StallE, FlushE, FlushM, MulDoneE};
        exp = expCtrl();
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, act, exp);
        end
        checks++;
        assert (StallCount === CNT_W'(modelCount)) else begin
            errors++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, StallCount, modelCount);
        end
    endtask

    // Advance one clock edge and move the model forward with the inputs seen before the edge.
    task automatic tick();
        logic [6:0] e;
        int nextDone;
        int nextCount;
        e         = expCtrl();
        nextCount = modelCount;
        nextDone  = cyclesToDone;
        if (e[5] && modelCount < CNT_MAX) nextCount = modelCount + 1;
        if (cyclesToDone > 0)                       nextDone = cyclesToDone - 1;
        else if (!BranchTakenE && MulStartE)        nextDone = MUL_LAT - 1;
        @(posedge clk);
        if (reset_n) begin
            modelCount   = nextCount;
            cyclesToDone = nextDone;
        end else begin
            modelCount   = 0;
            cyclesToDone = 0;
        end
        #1;
    endtask

    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic usesRt, input logic [4:0] rtE, input logic memRead,
                        input logic br, input logic mul);
        applyStimulus(rs, rt, usesRt, rtE, memRead, br, mul);
        #3;
        checkOutput(tag);
        tick();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        cyclesToDone = 0;
        modelCount   = 0;
        #1;
        checkOutput("reset_hold");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset with a load-use pattern present: everything must read zero.
        #3;
        checkOutput("reset_lu_inputs");
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("reset_release_lu");
        tick();

        // Load-use: one bubble, then the pipeline runs again.
        doReset();
        step("lu_rs",        5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step("lu_after",     5'd3, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("lu_rt_zero",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        step("lu_rt_unused", 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("lu_rt_used",   5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);

        // Branch beats both load-use and multiply, and the state stays RUN.
        step("br_priority",  5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        step("br_after",     5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

        // Multiply: three stall cycles that ignore hazards, then the result cycle.
        doReset();
        step("mul_c0", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        step("mul_c1", 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        step("mul_c2", 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        step("mul_c3", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        step("mul_c4", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 1 of a multiply: outputs drop at once and no result appears.
        step("mr_c0", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mr_c1_busy");
        doReset();
        for (int i = 0; i < 4; i++) step("mr_idle", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        step("mr_fresh_c0", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("mr_fresh", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

        // Back-to-back multiplies drive the 4-bit counter past its ceiling.
        doReset();
        for (int m = 0; m < 7; m++) begin
            step("sat_start", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < MUL_LAT - 1; i++) step("sat_busy", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        end
        step("sat_hold", 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        assert (StallCount === 4'd15) else begin
            errors++;
            $error("[TB] FAIL sat_final: observed %0d expected 15", StallCount);
        end

        // Random traffic with small register numbers so hazards actually hit.
        doReset();
        for (int i = 0; i < 400; i++) begin
            step("random",
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
